// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: walks every output neuron, streams input/weight
// addresses, lines accumulator strobes up with BRAM latency, writes each result, then reports done.
module fc_layer_seq #(
  parameter int Fully_Connect = 11,
  parameter int IN_LEN        = 98,
  parameter int OUT_LEN       = 2,
  parameter int RD_LAT        = 2,
  parameter int IDLE_ADDR     = 7878,
  parameter int WADDR_W       = 10,
  parameter int OADDR_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         state,
  output logic [12:0]        input_addr,
  output logic [WADDR_W-1:0] weight_addr,
  output logic               acc_clr,
  output logic               acc_en,
  output logic               out_we,
  output logic [OADDR_W-1:0] out_addr,
  output logic               done,
  output logic [2:0]         o_dbg_state
);

  localparam int KW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int NW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } st_t;

  st_t                r_st, w_nxt_st;
  logic [KW-1:0]      r_k, w_nxt_k;
  logic [NW-1:0]      r_n, w_nxt_n;
  logic [WADDR_W-1:0] r_w, w_nxt_w;
  logic [2:0]         r_dcnt, w_nxt_dcnt;
  logic [RD_LAT:0]    r_iss_dly;
  logic [RD_LAT:0]    r_first_dly;
  logic               w_start;
  logic               w_issue;

  assign w_start     = (state == 4'(Fully_Connect));
  assign w_issue     = (w_nxt_st == S_RUN);
  assign o_dbg_state = r_st;
  assign weight_addr = r_w;
  assign acc_en      = r_iss_dly[RD_LAT];
  // The first-term bit is only ever set together with issue, so it is already qualified.
  assign acc_clr     = r_first_dly[RD_LAT];

  always_comb begin
    w_nxt_st   = r_st;
    w_nxt_k    = r_k;
    w_nxt_n    = r_n;
    w_nxt_w    = r_w;
    w_nxt_dcnt = '0;
    case (r_st)
      S_IDLE: begin
        w_nxt_k = '0;
        w_nxt_n = '0;
        w_nxt_w = '0;
        if (w_start) w_nxt_st = S_RUN;
      end
      S_RUN: begin
        if (r_k == KW'(IN_LEN - 1)) begin
          w_nxt_st = S_DRAIN;
          w_nxt_k  = '0;
        end else begin
          w_nxt_k = r_k + 1'b1;
          w_nxt_w = r_w + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == 3'(RD_LAT - 1)) w_nxt_st = S_WRITE;
        else                          w_nxt_dcnt = r_dcnt + 3'd1;
      end
      S_WRITE: begin
        if (r_n == NW'(OUT_LEN - 1)) begin
          w_nxt_st = S_DONE;
        end else begin
          // w keeps counting, so the next neuron begins at (n+1)*IN_LEN
          w_nxt_st = S_RUN;
          w_nxt_n  = r_n + 1'b1;
          w_nxt_w  = r_w + 1'b1;
        end
      end
      S_DONE:  w_nxt_st = S_DONE;
      default: w_nxt_st = S_IDLE;
    endcase
    // Losing the layer state aborts from anywhere and restarts cleanly later.
    if (!w_start) begin
      w_nxt_st   = S_IDLE;
      w_nxt_k    = '0;
      w_nxt_n    = '0;
      w_nxt_w    = '0;
      w_nxt_dcnt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st        <= S_IDLE;
      r_k         <= '0;
      r_n         <= '0;
      r_w         <= '0;
      r_dcnt      <= '0;
      r_iss_dly   <= '0;
      r_first_dly <= '0;
      input_addr  <= 13'(IDLE_ADDR);
      out_we      <= 1'b0;
      out_addr    <= '0;
      done        <= 1'b0;
    end else begin
      r_st       <= w_nxt_st;
      r_k        <= w_nxt_k;
      r_n        <= w_nxt_n;
      r_w        <= w_nxt_w;
      r_dcnt     <= w_nxt_dcnt;
      input_addr <= w_issue ? 13'(w_nxt_k) : 13'(IDLE_ADDR);
      out_we     <= (w_nxt_st == S_WRITE);
      out_addr   <= OADDR_W'(w_nxt_n);
      done       <= (w_nxt_st == S_DONE);
      if (w_nxt_st == S_IDLE) begin
        r_iss_dly   <= '0;
        r_first_dly <= '0;
      end else begin
        r_iss_dly   <= {r_iss_dly[RD_LAT-1:0], w_issue};
        r_first_dly <= {r_first_dly[RD_LAT-1:0], w_issue && (w_nxt_k == '0)};
      end
    end
  end

endmodule
